// File: rtl/raster_pkg.sv
// Shared constants and types for the tile rasterizer: fixed-point format,
// default field widths and the walker state encoding.
package raster_pkg;

  localparam int unsigned FracBits = 8;
  localparam int unsigned OneFx    = 256;
  localparam int unsigned LWidth   = 32;
  localparam int unsigned ZWidth   = 16;
  localparam int unsigned IdWidth  = 16;
  localparam int unsigned TileW    = 8;
  localparam int unsigned TileH    = 8;
  localparam int unsigned XWidth   = $clog2(TileW);
  localparam int unsigned YWidth   = $clog2(TileH);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWalk = 1'b1
  } walk_state_e;

endpackage

// File: rtl/tile_walk_if.sv
// Triangle setup handshake from lambdagen plus the fragment output stream.
// master drives setup and frag_ready; slave is the tile walker.
interface tile_walk_if #(
  parameter int unsigned LW  = raster_pkg::LWidth,
  parameter int unsigned ZW  = raster_pkg::ZWidth,
  parameter int unsigned IdW = raster_pkg::IdWidth,
  parameter int unsigned XW  = raster_pkg::XWidth,
  parameter int unsigned YW  = raster_pkg::YWidth
) ();

  logic           in_valid;
  logic           busy;
  logic [LW-1:0]  l1;
  logic [LW-1:0]  l2;
  logic [LW-1:0]  dl1x;
  logic [LW-1:0]  dl2x;
  logic [LW-1:0]  dl1y;
  logic [LW-1:0]  dl2y;
  logic [LW-1:0]  z_;
  logic [LW-1:0]  dzx;
  logic [LW-1:0]  dzy;
  logic [IdW-1:0] tid_in;

  logic           frag_valid;
  logic           frag_ready;
  logic [XW-1:0]  frag_x;
  logic [YW-1:0]  frag_y;
  logic [ZW-1:0]  frag_z;
  logic [IdW-1:0] frag_tid;
  logic           tile_done;

  modport master (
    output in_valid, l1, l2, dl1x, dl2x, dl1y, dl2y, z_, dzx, dzy, tid_in, frag_ready,
    input  busy, frag_valid, frag_x, frag_y, frag_z, frag_tid, tile_done
  );

  modport slave (
    input  in_valid, l1, l2, dl1x, dl2x, dl1y, dl2y, z_, dzx, dzy, tid_in, frag_ready,
    output busy, frag_valid, frag_x, frag_y, frag_z, frag_tid, tile_done
  );

endinterface

// File: rtl/raster_cover.sv
// Combinational pixel test: barycentric coverage (edges inclusive) and
// conversion of 24.8 depth to a saturated signed integer.
module raster_cover
  import raster_pkg::*;
#(
  parameter int unsigned LW = raster_pkg::LWidth,
  parameter int unsigned ZW = raster_pkg::ZWidth
) (
  input  logic signed [LW-1:0] l1_i,
  input  logic signed [LW-1:0] l2_i,
  input  logic signed [LW-1:0] z_i,
  output logic                 covered_o,
  output logic [ZW-1:0]        z_o
);

  localparam logic signed [LW-1:0] ZMax = LW'(2 ** (ZW - 1) - 1);
  localparam logic signed [LW-1:0] ZMin = ~ZMax;

  logic [LW:0]          sum;
  logic signed [LW-1:0] z_shr;

  // One extra bit so two large positive lambdas cannot wrap under the limit.
  assign sum       = {l1_i[LW-1], l1_i} + {l2_i[LW-1], l2_i};
  assign covered_o = !l1_i[LW-1] && !l2_i[LW-1] && (sum <= (LW+1)'(OneFx));
  assign z_shr     = z_i >>> FracBits;

  always_comb begin
    if (z_shr > ZMax) begin
      z_o = {1'b0, {(ZW-1){1'b1}}};
    end else if (z_shr < ZMin) begin
      z_o = {1'b1, {(ZW-1){1'b0}}};
    end else begin
      z_o = z_shr[ZW-1:0];
    end
  end

endmodule

// File: rtl/tile_walk.sv
// Walks every pixel of a tile in raster order, stepping lambda/z accumulators
// and emitting one registered fragment per covered pixel with back-pressure.
module tile_walk
  import raster_pkg::*;
#(
  parameter int unsigned TileW = raster_pkg::TileW,
  parameter int unsigned TileH = raster_pkg::TileH,
  parameter int unsigned LW    = raster_pkg::LWidth,
  parameter int unsigned ZW    = raster_pkg::ZWidth,
  parameter int unsigned IdW   = raster_pkg::IdWidth
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  tile_walk_if.slave bus
);

  localparam int unsigned XW = $clog2(TileW);
  localparam int unsigned YW = $clog2(TileH);

  walk_state_e state_q, state_d;

  logic signed [LW-1:0] l1_q, l1_d, l2_q, l2_d, z_q, z_d;
  logic signed [LW-1:0] r1_q, r1_d, r2_q, r2_d, rz_q, rz_d;
  logic signed [LW-1:0] dl1x_q, dl1x_d, dl2x_q, dl2x_d, dzx_q, dzx_d;
  logic signed [LW-1:0] dl1y_q, dl1y_d, dl2y_q, dl2y_d, dzy_q, dzy_d;
  logic [IdW-1:0]       tid_q, tid_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;

  logic                 fv_q, fv_d;
  logic [XW-1:0]        fx_q, fx_d;
  logic [YW-1:0]        fy_q, fy_d;
  logic [ZW-1:0]        fz_q, fz_d;
  logic [IdW-1:0]       ftid_q, ftid_d;
  logic                 done_q, done_d;

  logic                 covered;
  logic [ZW-1:0]        z_sat;
  logic                 slot_free;
  logic                 last_x, last_y;

  raster_cover #(
    .LW (LW),
    .ZW (ZW)
  ) u_cover (
    .l1_i      (l1_q),
    .l2_i      (l2_q),
    .z_i       (z_q),
    .covered_o (covered),
    .z_o       (z_sat)
  );

  assign slot_free = !fv_q || bus.frag_ready;
  assign last_x    = (x_q == XW'(TileW - 1));
  assign last_y    = (y_q == YW'(TileH - 1));

  always_comb begin
    state_d = state_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    z_d     = z_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    rz_d    = rz_q;
    dl1x_d  = dl1x_q;
    dl2x_d  = dl2x_q;
    dzx_d   = dzx_q;
    dl1y_d  = dl1y_q;
    dl2y_d  = dl2y_q;
    dzy_d   = dzy_q;
    tid_d   = tid_q;
    x_d     = x_q;
    y_d     = y_q;
    fv_d    = fv_q && !bus.frag_ready;
    fx_d    = fx_q;
    fy_d    = fy_q;
    fz_d    = fz_q;
    ftid_d  = ftid_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StWalk;
          l1_d    = bus.l1;
          l2_d    = bus.l2;
          z_d     = bus.z_;
          r1_d    = bus.l1;
          r2_d    = bus.l2;
          rz_d    = bus.z_;
          dl1x_d  = bus.dl1x;
          dl2x_d  = bus.dl2x;
          dzx_d   = bus.dzx;
          dl1y_d  = bus.dl1y;
          dl2y_d  = bus.dl2y;
          dzy_d   = bus.dzy;
          tid_d   = bus.tid_in;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StWalk: begin
        // A full output register freezes the whole walk until it drains.
        if (slot_free) begin
          if (covered) begin
            fv_d   = 1'b1;
            fx_d   = x_q;
            fy_d   = y_q;
            fz_d   = z_sat;
            ftid_d = tid_q;
          end
          if (last_x) begin
            x_d = '0;
            if (last_y) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              y_d  = y_q + YW'(1);
              r1_d = r1_q + dl1y_q;
              r2_d = r2_q + dl2y_q;
              rz_d = rz_q + dzy_q;
              l1_d = r1_q + dl1y_q;
              l2_d = r2_q + dl2y_q;
              z_d  = rz_q + dzy_q;
            end
          end else begin
            x_d  = x_q + XW'(1);
            l1_d = l1_q + dl1x_q;
            l2_d = l2_q + dl2x_q;
            z_d  = z_q + dzx_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      l1_q    <= '0;
      l2_q    <= '0;
      z_q     <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      rz_q    <= '0;
      dl1x_q  <= '0;
      dl2x_q  <= '0;
      dzx_q   <= '0;
      dl1y_q  <= '0;
      dl2y_q  <= '0;
      dzy_q   <= '0;
      tid_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fv_q    <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      fz_q    <= '0;
      ftid_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      z_q     <= z_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      rz_q    <= rz_d;
      dl1x_q  <= dl1x_d;
      dl2x_q  <= dl2x_d;
      dzx_q   <= dzx_d;
      dl1y_q  <= dl1y_d;
      dl2y_q  <= dl2y_d;
      dzy_q   <= dzy_d;
      tid_q   <= tid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fv_q    <= fv_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fz_q    <= fz_d;
      ftid_q  <= ftid_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.frag_valid = fv_q;
  assign bus.frag_x     = fx_q;
  assign bus.frag_y     = fy_q;
  assign bus.frag_z     = fz_q;
  assign bus.frag_tid   = ftid_q;
  assign bus.tile_done  = done_q;

endmodule

// File: tb/tb_tile_walk.sv
// Directed bench for tile_walk: full, edge, gradient, empty, saturation,
// back-pressure and mid-walk reset scenarios against hand-computed fragments.
module tb_tile_walk;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  tile_walk_if bus ();

  tile_walk dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [15:0] tid;
    logic [15:0] z;
    logic [2:0]  x;
    logic [2:0]  y;
  } frag_t;

  frag_t       fq[$];
  int unsigned busy_cnt  = 0;
  int unsigned done_cnt  = 0;
  logic        done_busy = 1'b0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  // Record every transfer; the transfer itself happens on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) busy_cnt <= busy_cnt + 1;
      if (bus.tile_done) begin
        done_cnt  <= done_cnt + 1;
        done_busy <= bus.busy;
      end
      if (bus.frag_valid && bus.frag_ready) begin
        fq.push_back(frag_t'({bus.frag_tid, bus.frag_z, bus.frag_x, bus.frag_y}));
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input string tag, input logic [31:0] l1, input logic [31:0] l2,
                        input logic [31:0] d1x, input logic [31:0] d2x,
                        input logic [31:0] d1y, input logic [31:0] d2y,
                        input logic [31:0] z0, input logic [31:0] dzx,
                        input logic [31:0] dzy, input logic [15:0] tid);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    bus.l1 = l1;   bus.l2 = l2;
    bus.dl1x = d1x; bus.dl2x = d2x;
    bus.dl1y = d1y; bus.dl2y = d2y;
    bus.z_ = z0;   bus.dzx = dzx;  bus.dzy = dzy;
    bus.tid_in = tid;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(posedge clk);
      #1;
      ok = bus.busy;
    end
    bus.in_valid = 1'b0;
    check({tag, "/accept"}, 64'(ok), 64'd1);
  endtask

  // Fragment i is expected at (i % xmod, i / xmod) with depth exp_z + i*zinc.
  task automatic run_tile(input string tag, input logic [31:0] l1, input logic [31:0] l2,
                          input logic [31:0] d1x, input logic [31:0] d2x,
                          input logic [31:0] z0, input logic [31:0] dzx,
                          input logic [31:0] dzy, input logic [15:0] tid, input int exp_n,
                          input int xmod, input logic [15:0] exp_z, input int zinc,
                          input bit bp);
    int          base  = fq.size();
    int unsigned busy0 = busy_cnt;
    int unsigned done0 = done_cnt;
    launch(tag, l1, l2, d1x, d2x, 32'd0, 32'd0, z0, dzx, dzy, tid);
    if (bp) begin
      for (int c = 0; c < 200 && (int'(fq.size()) - base) < 3; c++) begin
        @(posedge clk);
        #1;
      end
      check({tag, "/bp_start"}, 64'(int'(fq.size()) - base), 64'd3);
      bus.frag_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check({tag, "/hold_v"}, 64'(bus.frag_valid), 64'd1);
        check({tag, "/hold_x"}, 64'(bus.frag_x), 64'd3);
        check({tag, "/hold_y"}, 64'(bus.frag_y), 64'd0);
        check({tag, "/hold_z"}, 64'(bus.frag_z), 64'(exp_z));
      end
      @(posedge clk);
      #1;
      bus.frag_ready = 1'b1;
    end
    for (int c = 0; c < 300 && done_cnt == done0; c++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "/done_cnt"}, 64'(done_cnt - done0), 64'd1);
    check({tag, "/done_idle"}, 64'(done_busy), 64'd0);
    check({tag, "/count"}, 64'(int'(fq.size()) - base), 64'(exp_n));
    if (!bp) check({tag, "/busy_cycles"}, 64'(busy_cnt - busy0), 64'd64);
    for (int i = 0; i < exp_n && (base + i) < int'(fq.size()); i++) begin
      check({tag, "/x"}, 64'(fq[base+i].x), 64'(i % xmod));
      check({tag, "/y"}, 64'(fq[base+i].y), 64'(i / xmod));
      check({tag, "/z"}, 64'(fq[base+i].z), 64'(16'(exp_z + 16'(i * zinc))));
      check({tag, "/tid"}, 64'(fq[base+i].tid), 64'(tid));
    end
  endtask

  initial begin
    int          base;
    int unsigned done0;
    bus.in_valid = 1'b0;
    bus.l1 = '0;   bus.l2 = '0;
    bus.dl1x = '0; bus.dl2x = '0;
    bus.dl1y = '0; bus.dl2y = '0;
    bus.z_ = '0;   bus.dzx = '0;  bus.dzy = '0;
    bus.tid_in = '0;
    bus.frag_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check("rst/busy", 64'(bus.busy), 64'd0);
    check("rst/frag_valid", 64'(bus.frag_valid), 64'd0);
    check("rst/tile_done", 64'(bus.tile_done), 64'd0);
    check("rst/frag_z", 64'(bus.frag_z), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_tile("full", 32'h0, 32'h0, 32'h0, 32'h0, 32'h500, 32'h0, 32'h0, 16'h0011,
             64, 8, 16'd5, 0, 1'b0);
    run_tile("edge", 32'h100, 32'h0, -32'sh40, 32'h40, 32'h500, 32'h0, 32'h0, 16'h0022,
             40, 5, 16'd5, 0, 1'b0);
    run_tile("grad", 32'h0, 32'h0, 32'h0, 32'h0, 32'h500, 32'h100, 32'h800, 16'h0033,
             64, 8, 16'd5, 1, 1'b0);
    run_tile("empty", 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h500, 32'h0, 32'h0, 16'h0044,
             0, 8, 16'd0, 0, 1'b0);
    run_tile("sat_hi", 32'h0, 32'h0, 32'h0, 32'h0, 32'h7FFF_FF00, 32'h0, 32'h0, 16'h0055,
             64, 8, 16'h7FFF, 0, 1'b0);
    run_tile("sat_lo", 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 16'h0066,
             64, 8, 16'h8000, 0, 1'b0);
    run_tile("bp", 32'h0, 32'h0, 32'h0, 32'h0, 32'h500, 32'h0, 32'h0, 16'h0077,
             64, 8, 16'd5, 0, 1'b1);

    // Mid-walk reset: abandon the tile after 20 fragments.
    base = fq.size();
    launch("rstmid", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h500, 32'h0, 32'h0,
           16'h0088);
    for (int c = 0; c < 200 && (int'(fq.size()) - base) < 20; c++) begin
      @(posedge clk);
      #1;
    end
    check("rstmid/reached", 64'(int'(fq.size()) - base), 64'd20);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid/busy", 64'(bus.busy), 64'd0);
    check("rstmid/frag_valid", 64'(bus.frag_valid), 64'd0);
    check("rstmid/frag_x", 64'(bus.frag_x), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base  = fq.size();
    done0 = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("rstmid/no_frag", 64'(int'(fq.size()) - base), 64'd0);
    check("rstmid/no_done", 64'(done_cnt - done0), 64'd0);
    run_tile("after_rst", 32'h0, 32'h0, 32'h0, 32'h0, 32'h500, 32'h0, 32'h0, 16'h0099,
             64, 8, 16'd5, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
